// File: rtl/an_code_pkg.sv
// Shared definitions for the AN-code (A = 655) double-error-correction path:
// code constants, the residue FSM state type and the single modular step
// used by the residue unit, the r-LUT and the corrector.
package an_code_pkg;

    localparam int AN_A   = 655;
    localparam int AN_W   = 14;
    localparam int AN_R_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } an_state_t;

    // (2*acc + b) mod AN_A for acc < AN_A: the doubled value is below
    // 2*AN_A, so one conditional subtract fully reduces it.
    function automatic logic [AN_R_W-1:0] an_mod_step(
        input logic [AN_R_W-1:0] acc,
        input logic              b
    );
        logic [AN_R_W:0] t;
        t = {acc, b};
        if (t >= (AN_R_W+1)'(AN_A))
            return AN_R_W'(t - (AN_R_W+1)'(AN_A));
        else
            return t[AN_R_W-1:0];
    endfunction

endpackage

// File: rtl/an_mod_step_unit.sv
// One MSB-first modular reduction step: o_acc = (2*i_acc + i_bit) mod A.
// Requires i_acc < A, which keeps the doubled value below 2*A.
module an_mod_step_unit
    import an_code_pkg::*;
#(
    parameter int A   = AN_A,
    parameter int R_W = AN_R_W
) (
    input  logic [R_W-1:0] i_acc,
    input  logic           i_bit,
    output logic [R_W-1:0] o_acc
);

    logic [R_W:0] w_t;

    // Shift in the next codeword bit, then reduce with a single subtract.
    always_comb begin
        w_t = {i_acc, i_bit};
        if (w_t >= (R_W+1)'(A))
            o_acc = R_W'(w_t - (R_W+1)'(A));
        else
            o_acc = w_t[R_W-1:0];
    end

endmodule

// File: rtl/an_residue_serial.sv
// Bit-serial residue unit: computes r = N mod A for a received AN codeword,
// MSB first over W cycles, and hands r plus the original N downstream with
// a valid/ready handshake. One codeword in flight at a time.
module an_residue_serial
    import an_code_pkg::*;
#(
    parameter int W     = AN_W,
    parameter int A     = AN_A,
    parameter int R_W   = AN_R_W,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_cw,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [R_W-1:0] r_out,
    output logic [W-1:0]   cw_out,
    output logic           syn_zero
);

    an_state_t        r_state;
    an_state_t        w_next_state;
    logic [W-1:0]     r_sh;
    logic [W-1:0]     r_cw;
    logic [R_W-1:0]   r_acc;
    logic [R_W-1:0]   r_rem;
    logic             r_syn;
    logic [CNT_W-1:0] r_cnt;

    logic [R_W-1:0]   w_acc_next;
    logic             w_accept;
    logic             w_last;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == CNT_W'(W - 1));

    an_mod_step_unit #(
        .A   (A),
        .R_W (R_W)
    ) u_step (
        .i_acc (r_acc),
        .i_bit (r_sh[W-1]),
        .o_acc (w_acc_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic: accept in IDLE, W steps in CALC, hold in DONE until taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = CALC;
            CALC:    if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // Datapath: load on accept, shift/reduce during CALC, latch result on the last step.
    // in_cw only reaches any state through the accept load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cw  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_rem <= '0;
            r_syn <= 1'b0;
        end else if (w_accept) begin
            r_sh  <= in_cw;
            r_cw  <= in_cw;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == CALC) begin
            r_acc <= w_acc_next;
            r_sh  <= r_sh << 1;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_rem <= w_acc_next;
                r_syn <= (w_acc_next == '0);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign r_out     = r_rem;
    assign cw_out    = r_cw;
    assign syn_zero  = r_syn;

endmodule

// File: tb/tb_an_residue_serial.sv
// Bench for an_residue_serial: directed vector table, reset and backpressure
// sequences, then randomized traffic against an N % 655 reference queue.
module tb_an_residue_serial;

    localparam int W   = 14;
    localparam int A   = 655;
    localparam int R_W = 10;
    localparam int NUM_RAND = 1500;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_cw = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [R_W-1:0] r_out;
    logic [W-1:0]   cw_out;
    logic           syn_zero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    an_residue_serial #(.W(W), .A(A), .R_W(R_W), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cw     (in_cw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_out     (r_out),
        .cw_out    (cw_out),
        .syn_zero  (syn_zero)
    );

    typedef struct {
        int    n;
        int    r;
        int    syn;
        string name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Waits (bounded) for out_valid after an accept edge; returns cycles or -1.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check({nm, "_in_ready"}, int'(in_ready), 1);
    endtask

    task automatic run_one(input int n, input int exp_r, input int exp_syn, input string nm);
        int lat;
        wait_ready(nm);
        in_cw    = W'(n);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({nm, "_busy"}, int'(in_ready), 0);
        wait_done(lat);
        check({nm, "_latency"}, lat, W);
        check({nm, "_r_out"}, int'(r_out), exp_r);
        check({nm, "_cw_out"}, int'(cw_out), n);
        check({nm, "_syn_zero"}, int'(syn_zero), exp_syn);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "_vld_drop"}, int'(out_valid), 0);
        check({nm, "_idle_rdy"}, int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        int sent;
        int got;
        int cyc;
        int exp_n;
        int q[$];

        vecs[0] = '{4585,  0,   1, "clean_4585"};
        vecs[1] = '{4587,  2,   0, "err_4587"};
        vecs[2] = '{4584,  654, 0, "err_4584"};
        vecs[3] = '{0,     0,   1, "zero"};
        vecs[4] = '{16383, 8,   0, "max_16383"};
        vecs[5] = '{655,   0,   1, "eq_A"};
        vecs[6] = '{654,   654, 0, "A_minus_1"};
        vecs[7] = '{1000,  345, 0, "n_1000"};

        // Reset state while rst_n is held low.
        #7;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_r_out", int'(r_out), 0);
        check("rst_cw_out", int'(cw_out), 0);
        check("rst_syn_zero", int'(syn_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of CALC discards the codeword.
        in_cw = W'(1000);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("midrst_calc_busy", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_r_out", int'(r_out), 0);
        check("midrst_cw_out", int'(cw_out), 0);
        check("midrst_syn_zero", int'(syn_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_out_valid", int'(out_valid), 0);
        run_one(1000, 345, 0, "after_rst_1000");

        // Directed vector table.
        for (int i = 0; i < 8; i++)
            run_one(vecs[i].n, vecs[i].r, vecs[i].syn, vecs[i].name);

        // Backpressure: hold DONE for 20 cycles with in_valid noise, then
        // release with a codeword already waiting on the input.
        wait_ready("bp");
        in_cw = W'(4587);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(lat);
        check("bp_latency", lat, W);
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            in_cw    = W'(1234 + c);
            @(posedge clk); #1;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_r_out", int'(r_out), 2);
            check("bp_cw_out", int'(cw_out), 4587);
        end
        in_cw = W'(1234);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_rel_out_valid", int'(out_valid), 0);
        check("bp_rel_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_queued_accept", int'(in_ready), 0);
        wait_done(lat);
        check("bp_queued_latency", lat, W);
        check("bp_queued_r_out", int'(r_out), 1234 % A);
        check("bp_queued_cw_out", int'(cw_out), 1234);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Randomized traffic against the reference queue.
        sent = 0;
        got = 0;
        cyc = 0;
        while (got < NUM_RAND && cyc < 90000) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(int'(in_cw));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious_output", 1, 0);
                end else begin
                    exp_n = q.pop_front();
                    check("rand_r_out", int'(r_out), exp_n % A);
                    check("rand_cw_out", int'(cw_out), exp_n);
                    check("rand_syn_zero", int'(syn_zero), int'((exp_n % A) == 0));
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            in_valid = (sent < NUM_RAND) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       in_cw = W'(A * $urandom_range(0, 25));
                1:       in_cw = W'(16383 - $urandom_range(0, 3));
                2:       in_cw = W'($urandom_range(0, 3));
                default: in_cw = W'($urandom_range(0, 16383));
            endcase
            out_ready = ($urandom_range(0, 2) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rand_all_received", got, NUM_RAND);
        check("rand_all_sent", sent, NUM_RAND);
        check("rand_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
